// File: rtl/rv_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port plus the decode and execute
// side signals. master = fetch unit, slave = memory/pipeline environment.
interface rv_fetch_if;
    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic [31:0] im_data_i;
    logic        im_valid_i;
    logic        f_stall_i;
    logic        f_kill_i;
    logic        x_bra_i;
    logic [31:0] x_bra_target_i;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_valid_o;

    modport master (
        output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o,
        input  im_data_i, im_valid_i, f_stall_i, f_kill_i, x_bra_i, x_bra_target_i
    );

    modport slave (
        input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o,
        output im_data_i, im_valid_i, f_stall_i, f_kill_i, x_bra_i, x_bra_target_i
    );
endinterface

// File: rtl/rv_fetch.sv
// uRV instruction fetch: PC, single outstanding memory read, one skid entry
// so a word arriving under a decode stall is never lost.
module rv_fetch #(
    parameter logic [31:0] g_reset_vector = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    rv_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_f_valid;
    logic [31:0] r_f_ir;
    logic [31:0] r_f_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_ir;
    logic [31:0] r_skid_pc;

    logic        w_accept;
    logic        w_fill;
    logic        w_rd;
    logic [31:0] w_target;

    assign w_target = {bus.x_bra_target_i[31:2], 2'b00};

    // A response is only used if it belongs to a live request and no flush
    // arrives with it; issue stalls whenever the word would land in the skid.
    always_comb begin
        w_accept = bus.im_valid_i && (r_state == S_WAIT) && !bus.x_bra_i && !bus.f_kill_i;
        w_fill   = w_accept && bus.f_stall_i;
        w_rd     = !rst_i && !bus.x_bra_i && !r_skid_valid &&
                   ((r_state == S_IDLE) || bus.im_valid_i) && !w_fill;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rd) w_state_nxt = S_WAIT;
            end
            S_WAIT, S_DROP: begin
                if (bus.im_valid_i)
                    w_state_nxt = w_rd ? S_WAIT : S_IDLE;
                else if ((r_state == S_WAIT) && bus.x_bra_i)
                    w_state_nxt = S_DROP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= ((r_state != S_IDLE) && !bus.im_valid_i) ? S_DROP : S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc         <= g_reset_vector;
            r_req_pc     <= '0;
            r_f_valid    <= 1'b0;
            r_f_ir       <= '0;
            r_f_pc       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ir    <= '0;
            r_skid_pc    <= '0;
        end else begin
            if (w_rd) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end
            if (bus.x_bra_i) begin
                r_pc         <= w_target;
                r_f_valid    <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (bus.f_kill_i) begin
                r_f_valid    <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (bus.f_stall_i) begin
                if (w_accept) begin
                    r_skid_valid <= 1'b1;
                    r_skid_ir    <= bus.im_data_i;
                    r_skid_pc    <= r_req_pc;
                end
            end else if (r_skid_valid) begin
                r_f_ir       <= r_skid_ir;
                r_f_pc       <= r_skid_pc;
                r_f_valid    <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_f_ir    <= bus.im_data_i;
                r_f_pc    <= r_req_pc;
                r_f_valid <= 1'b1;
            end else begin
                r_f_valid <= 1'b0;
            end
        end
    end

    assign bus.im_addr_o = r_pc;
    assign bus.im_rd_o   = w_rd;
    assign bus.f_ir_o    = r_f_ir;
    assign bus.f_pc_o    = r_f_pc;
    assign bus.f_valid_o = r_f_valid;

endmodule

// File: tb/tb_rv_fetch.sv
// Bench for rv_fetch: directed cycle table for the corner cases, then random
// stall/kill/branch/reset traffic against a queue-based reference model.
module tb_rv_fetch;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic clk_i = 1'b0;
    logic rst_i;

    rv_fetch_if bus ();

    rv_fetch #(.g_reset_vector(RV)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    // memory side: pending requests with the cycle their answer becomes visible
    typedef struct { logic [31:0] addr; int unsigned ready; } mreq_t;
    mreq_t mq[$];

    // reference model: outstanding requests in order, each possibly condemned
    typedef struct { logic [31:0] pc; bit drop; } oreq_t;
    oreq_t oq[$];
    logic [31:0] m_pc    = RV;
    bit          m_fv    = 1'b0;
    logic [31:0] m_fir   = '0;
    logic [31:0] m_fpc   = '0;
    bit          m_sk_v  = 1'b0;
    logic [31:0] m_sk_ir = '0;
    logic [31:0] m_sk_pc = '0;

    typedef struct {
        bit          rst, stall, bra;
        logic [31:0] tgt;
        int unsigned lat;
        bit          chk, ev;
        logic [31:0] epc;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t v(input bit rst, input bit stall, input bit bra,
                               input logic [31:0] tgt, input int unsigned lat,
                               input bit chk, input bit ev, input logic [31:0] epc);
        vec_t r;
        r.rst = rst; r.stall = stall; r.bra = bra; r.tgt = tgt; r.lat = lat;
        r.chk = chk; r.ev = ev; r.epc = epc;
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit stall, input bit kill, input bit bra,
                        input logic [31:0] tgt, input int unsigned lat);
        bit          vin, resp, keep, rd_exp, rd_act;
        logic [31:0] data, addr_act;
        oreq_t       head;
        rst_i              = rst;
        bus.f_stall_i      = stall;
        bus.f_kill_i       = kill;
        bus.x_bra_i        = bra;
        bus.x_bra_target_i = tgt;
        vin  = (mq.size() > 0) && (mq[0].ready <= cyc);
        data = vin ? mem_word(mq[0].addr) : $urandom();
        bus.im_valid_i = vin;
        bus.im_data_i  = data;
        #1;
        resp   = vin && (oq.size() > 0);
        keep   = resp && !oq[0].drop && !bra && !kill && !rst;
        rd_exp = !rst && !bra && !m_sk_v && ((oq.size() == 0) || vin) && !(keep && stall);
        rd_act   = bus.im_rd_o;
        addr_act = bus.im_addr_o;
        check32("im_rd_o", {31'd0, rd_act}, {31'd0, rd_exp});
        if (rd_exp) check32("im_addr_o", addr_act, m_pc);
        @(posedge clk_i);
        if (vin) void'(mq.pop_front());
        if (rd_act) mq.push_back('{addr_act, cyc + lat});
        cyc++;
        if (resp) head = oq.pop_front();
        if (rst) begin
            m_pc = RV; m_fv = 1'b0; m_fir = '0; m_fpc = '0; m_sk_v = 1'b0;
            foreach (oq[i]) oq[i].drop = 1'b1;
        end else begin
            if (rd_exp) begin
                oq.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (bra) begin
                m_pc = tgt & ~32'd3;
                foreach (oq[i]) oq[i].drop = 1'b1;
                m_fv = 1'b0; m_sk_v = 1'b0;
            end else if (kill) begin
                m_fv = 1'b0; m_sk_v = 1'b0;
            end else if (stall) begin
                if (keep) begin
                    m_sk_v = 1'b1; m_sk_ir = data; m_sk_pc = head.pc;
                end
            end else if (m_sk_v) begin
                m_fv = 1'b1; m_fir = m_sk_ir; m_fpc = m_sk_pc; m_sk_v = 1'b0;
            end else if (keep) begin
                m_fv = 1'b1; m_fir = data; m_fpc = head.pc;
            end else begin
                m_fv = 1'b0;
            end
        end
        #1;
        check32("f_valid_o", {31'd0, bus.f_valid_o}, {31'd0, m_fv});
        check32("f_pc_o", bus.f_pc_o, m_fpc);
        check32("f_ir_o", bus.f_ir_o, m_fir);
    endtask

    initial begin
        rst_i              = 1'b1;
        bus.f_stall_i      = 1'b0;
        bus.f_kill_i       = 1'b0;
        bus.x_bra_i        = 1'b0;
        bus.x_bra_target_i = '0;
        bus.im_valid_i     = 1'b0;
        bus.im_data_i      = '0;

        // zero-wait stream, 3-cycle stall with a word in flight
        tbl.push_back(v(1,0,0,0,1, 0,0,0));
        tbl.push_back(v(1,0,0,0,1, 1,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h0));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h4));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h8));
        tbl.push_back(v(0,1,0,0,1, 1,1,32'h8));
        tbl.push_back(v(0,1,0,0,1, 1,1,32'h8));
        tbl.push_back(v(0,1,0,0,1, 1,1,32'h8));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'hC));
        tbl.push_back(v(0,0,0,0,1, 0,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h10));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h14));
        // redirect while stalled
        tbl.push_back(v(0,1,1,32'h202,1, 1,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h200));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h204));
        // reset with a request outstanding, stale answer after release
        tbl.push_back(v(0,0,0,0,3, 1,1,32'h208));
        tbl.push_back(v(1,0,0,0,3, 1,0,0));
        tbl.push_back(v(0,0,0,0,3, 1,0,0));
        tbl.push_back(v(0,0,0,0,3, 1,0,0));
        tbl.push_back(v(0,0,0,0,3, 1,0,0));
        tbl.push_back(v(0,0,0,0,3, 1,0,0));
        tbl.push_back(v(0,0,0,0,3, 1,1,RV));
        // PC wrap at the top of the address space
        tbl.push_back(v(0,0,1,32'hFFFF_FFFC,1, 1,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,0,0));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'hFFFF_FFFC));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h0));
        tbl.push_back(v(0,0,0,0,1, 1,1,32'h4));
        // 2-cycle memory, redirect drops the in-flight 0x14 fetch
        tbl.push_back(v(1,0,0,0,2, 0,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,1,32'h0));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,1,32'h4));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,1,32'h8));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,1,32'hC));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,1,32'h10));
        tbl.push_back(v(0,0,1,32'h103,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,0,0));
        tbl.push_back(v(0,0,0,0,2, 1,1,32'h100));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].stall, 1'b0, tbl[i].bra, tbl[i].tgt, tbl[i].lat);
            if (tbl[i].chk) begin
                check32("tbl_valid", {31'd0, bus.f_valid_o}, {31'd0, tbl[i].ev});
                if (tbl[i].ev) begin
                    check32("tbl_pc", bus.f_pc_o, tbl[i].epc);
                    check32("tbl_ir", bus.f_ir_o, mem_word(tbl[i].epc));
                end
            end
        end

        for (int n = 0; n < 3000; n++) begin
            bit          r_rst, r_stall, r_kill, r_bra;
            logic [31:0] r_tgt;
            r_rst   = ($urandom_range(0, 99) < 2);
            r_stall = ($urandom_range(0, 99) < 30);
            r_kill  = ($urandom_range(0, 99) < 4);
            r_bra   = ($urandom_range(0, 99) < 5);
            r_tgt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom();
            step(r_rst, r_stall, r_kill, r_bra, r_tgt, $urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
